tpm_response_tx: RTL
====================

# tpm_response_tx

Serialises the TPM response for the command last handled by the management/execution path into a big-endian byte stream toward the host interface. Built once per command: capture tag, response code and payload length on a start pulse, then emit the 10-byte TPM response header followed by payload bytes pulled from the response buffer. This is the transmit end of the command/response path whose receive end feeds `tpm_cc`/`cmd_param` into the management module.

## Interface
- MAX_PAYLOAD, 4086, largest payload byte count accepted (response size ≤ MAX_PAYLOAD+10)
- LEN_W, 12, width of payload length and byte counter
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rsp_start  input  1  one-cycle request to build a response; honoured only in IDLE
- rsp_tag  input  16  requested tag (8001h TPM_ST_NO_SESSIONS, 8002h TPM_ST_SESSIONS)
- tpm_rc  input  32  response code from the management module
- payload_len  input  LEN_W  payload bytes following header
- pl_data  input  8  payload byte from response buffer
- pl_valid  input  1  pl_data valid
- pl_ready  output  1  payload byte consumed this cycle when pl_valid && pl_ready
- tx_data  output  8  response byte to host interface
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts tx_data when tx_valid && tx_ready
- busy  output  1  high from capture until done
- done  output  1  one-cycle pulse after final byte accepted
- len_err  output  1  sticky until next accepted rsp_start; set when payload_len > MAX_PAYLOAD

## Operation
- States: IDLE, HDR, PAYLOAD, DONE.
- IDLE: on rsp_start capture rsp_tag, tpm_rc, payload_len; go HDR. rsp_start outside IDLE ignored (no capture, no error).
- Capture rules, evaluated at start: if payload_len > MAX_PAYLOAD → rc := 0000_0101h (TPM_RC_FAILURE), tag := 8001h, len := 0, len_err := 1. Else if tpm_rc ≠ 0 → tag := 8001h, len := 0 (payload discarded, not consumed). Else tag/len as given; tag values other than 8001h/8002h are passed unchanged.
- response size = 10 + len, 32-bit, zero-extended.
- HDR emits 10 bytes MSB-first: tag[15:8], tag[7:0], size[31:24..7:0], rc[31:24..7:0]. 4-bit index 0..9.
- After byte 9 accepted: len = 0 → DONE; else PAYLOAD with counter = len.
- PAYLOAD: pass pl_data to tx_data; counter decrements per payload byte loaded; last byte accepted → DONE. pl_ready low in all other states.
- DONE: done = 1 for one cycle, busy falls, return IDLE.
- Output stage is a single register: new byte loads when !tx_valid || tx_ready. tx_data/tx_valid held stable while tx_valid && !tx_ready. In PAYLOAD, pl_ready = load slot free && counter ≠ 0; pl_valid low inserts bubble (tx_valid drops if previous byte accepted).

## Timing
- Reset values: tx_valid 0, tx_data 00h, pl_ready 0, busy 0, done 0, len_err 0, state IDLE, counters 0.
- rsp_start in cycle N → busy=1 and tx_valid=1 with byte 0 in cycle N+1.
- Throughput one byte per cycle with tx_ready and pl_valid held high; a 10+L response takes 10+L cycles from first tx_valid to last acceptance, done in the following cycle.
- pl_data to tx_data latency: one cycle.
- Asserted reset mid-response: immediate return to reset values; no partial byte held; next response starts cleanly from byte 0.
- rsp_start in the DONE cycle is ignored; first accepted start is the cycle after done.

## Test plan
- Success, no payload: tag 8001h, rc 0, len 0, tx_ready=1 → bytes 80 01 00 00 00 0A 00 00 00 00, done at cycle 11 after start.
- Success, payload 3 bytes AA BB CC, tag 8002h, tx_ready toggled 1/0 each cycle → 80 02 00 00 00 0D 00 00 00 00 AA BB CC, tx_data stable through every stall, pl_ready exactly 3 handshakes.
- Error rc 0000_0084h with tag 8002h, len 5 → 80 01 00 00 00 0A 00 00 00 84, pl_ready never high, len_err 0.
- Oversize len 4087 → 80 01 00 00 00 0A 00 00 01 01, len_err=1 until next start.
- rsp_start pulsed during HDR and in DONE cycle → ignored, stream unchanged, single done pulse.
- reset_n low after byte 4 → all outputs reset values immediately; new start yields full correct 10-byte header.

Source files
------------

// File: rtl/tpm_response_tx.sv
// tpm_response_tx: serialises a TPM response header plus payload into a big-endian byte stream
module tpm_response_tx #(
  parameter int MAX_PAYLOAD = 4086,
  parameter int LEN_W = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rsp_start,
  input  logic [15:0]      rsp_tag,
  input  logic [31:0]      tpm_rc,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             len_err
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;
  state_t state;
  logic [15:0] tagQ;
  logic [31:0] rcQ;
  logic [LEN_W-1:0] lenQ;
  logic [LEN_W-1:0] count;
  logic [3:0] idx;
  logic oversize;
  logic failed;
  logic slotFree;
  logic [15:0] capTag;
  logic [31:0] capRc;
  logic [LEN_W-1:0] capLen;
  logic [79:0] hdrVec;
  logic [79:0] hdrShift;
  // Capture-time rewriting of tag/rc/len, header byte selection and payload pull request
  always_comb begin
    oversize = 32'(payload_len) > 32'(MAX_PAYLOAD);
    failed = oversize || (tpm_rc != 32'd0);
    capTag = failed ? 16'h8001 : rsp_tag;
    capRc = oversize ? 32'h0000_0101 : tpm_rc;
    capLen = failed ? '0 : payload_len;
    hdrVec = {tagQ, 32'(lenQ) + 32'd10, rcQ};
    hdrShift = hdrVec << {idx, 3'b000};
    slotFree = !tx_valid || tx_ready;
    pl_ready = (state == PAYLOAD) && slotFree && (count != '0);
  end
  // Response FSM driving the single-register output stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tagQ <= '0;
      rcQ <= '0;
      lenQ <= '0;
      count <= '0;
      idx <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      len_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rsp_start) begin
            tagQ <= capTag;
            rcQ <= capRc;
            lenQ <= capLen;
            len_err <= oversize;
            tx_data <= capTag[15:8];
            tx_valid <= 1'b1;
            idx <= 4'd1;
            busy <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (slotFree) begin
            if (idx != 4'd10) begin
              tx_data <= hdrShift[79:72];
              tx_valid <= 1'b1;
              idx <= idx + 4'd1;
              if (idx == 4'd9 && lenQ != '0) begin
                count <= lenQ;
                state <= PAYLOAD;
              end
            end else begin
              tx_valid <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        PAYLOAD: begin
          if (slotFree) begin
            if (count != '0) begin
              tx_valid <= pl_valid;
              if (pl_valid) begin
                tx_data <= pl_data;
                count <= count - 1'b1;
              end
            end else begin
              tx_valid <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
